alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one ALU datapath between two requesters. The ALU computes subtract / nand / starting-ones / one-hot-to-U2 decode and returns a 4-bit flag vector.
- Arbitrates round-robin and latches the winner's operands and opcode into registers that drive the ALU.
- Captures the ALU result and flags, then returns them on a valid/ready response channel tagged with the requester id.
- Sits between the command sources and the ALU instance; the ALU stays purely combinational.

Parameters:
- WIDTH, 4, operand/result width (matches ALU WIDTH).
- OPW, 2, opcode width.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset; synchronous, active-low.
- i_req0_valid  in  1  requester 0 has a command.
- o_req0_ready  out  1  requester 0 command accepted this cycle.
- i_req0_oper  in  OPW  requester 0 opcode.
- i_req0_arg0  in  WIDTH  requester 0 operand A.
- i_req0_arg1  in  WIDTH  requester 0 operand B.
- i_req1_valid, o_req1_ready, i_req1_oper, i_req1_arg0, i_req1_arg1: same as requester 0, for requester 1.
- o_alu_arg0  out  WIDTH  registered operand A to ALU.
- o_alu_arg1  out  WIDTH  registered operand B to ALU.
- o_alu_oper  out  OPW  registered opcode to ALU.
- i_alu_result  in  WIDTH  ALU result.
- i_alu_flag  in  4  ALU flags {ovf, pos, neg, err}.
- o_rsp_valid  out  1  response available.
- i_rsp_ready  in  1  consumer takes response.
- o_rsp_id  out  1  requester that issued the command.
- o_rsp_result  out  WIDTH  captured result.
- o_rsp_flag  out  4  captured flags.

Behaviour:
- Reset (i_rstn=0 at a clock edge):
  - state=IDLE.
  - All registered outputs are 0: o_alu_*, o_rsp_*.
  - last_grant=1, so requester 0 has priority after reset.
  - Any in-flight transaction is dropped, with no response, whatever the state.
- State machine IDLE -> EXEC -> RESP -> IDLE. Minimum 3 cycles per transaction.
- IDLE:
  - o_reqN_ready is combinational: (state==IDLE) & i_reqN_valid & grantN.
  - Grant rule: if only one valid, grant it. If both valid, grant ~last_grant.
  - On valid&ready: latch oper/arg0/arg1 into o_alu_*, latch id, update last_grant=id, go to EXEC.
  - No valid: stay in IDLE; o_alu_* hold their previous values.
- EXEC: one settle cycle for the ALU. At the end of EXEC, register i_alu_result and i_alu_flag into o_rsp_result/o_rsp_flag, set o_rsp_valid=1, go to RESP.
- RESP:
  - o_rsp_* are held stable while o_rsp_valid=1 & i_rsp_ready=0.
  - Both o_reqN_ready are 0 throughout RESP.
  - On i_rsp_ready=1: o_rsp_valid=0 next cycle, go to IDLE. No same-cycle re-grant, i.e. no bypass from RESP to EXEC.
- Requester rules: must hold valid and payload stable until ready. Dropping valid before ready is legal and produces no grant.
- Opcodes 2'b00..2'b11 are passed unchecked. Flags are taken verbatim from the ALU; no local arithmetic.
- o_rsp_result/o_rsp_flag keep their last value after the handshake, until the next capture.

Optional Feature:
- ALU_ERR_CNT_EN defined:
  - Adds output o_err_cnt[7:0].
  - Increments on each response handshake (o_rsp_valid & i_rsp_ready) with o_rsp_flag[0]=1.
  - Saturates at 255; cleared by reset.
- ALU_ERR_CNT_EN undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package alu_pkg:
  - Opcode constants OP_SUB=2'b00, OP_NAND=2'b01, OP_ONES=2'b10, OP_DEC=2'b11.
  - Flag bit indices FLAG_ERR=0, FLAG_NEG=1, FLAG_POS=2, FLAG_OVF=3.
  - State encoding IDLE/EXEC/RESP.
- Sub-module rr_arb2: 2-way round-robin grant from valids and last_grant. Combinational, reusable.

Test Plan (WIDTH=4, bench connects the real ALU):
- Single request: req0 valid, OP_SUB, arg0=5, arg1=3, rsp_ready=1.
  -> ready0 in cycle 0; rsp_valid in cycle 2; result=4'd2, flag=4'b0100, id=0; back in IDLE by cycle 3.
- Contention: both valid continuously from reset, req0 OP_NAND 4'hF/4'hF, req1 OP_SUB 1/1.
  -> grant order 0,1,0,1. Responses: id0 result=0, flag=0000; id1 result=0.
- Backpressure: rsp_ready=0 for 5 cycles during RESP, req1 valid.
  -> o_rsp_* stable; ready1 stays 0 until 1 cycle after rsp_ready=1.
- Reset mid-operation: assert i_rstn=0 during EXEC.
  -> next cycle all outputs 0 and no response emitted. After release, both valid: req0 granted first.
- Withdraw: req1 valid for 1 cycle while in RESP, then low.
  -> no grant; in IDLE, o_req1_ready stays 0.
- Error counter (macro defined): 300 responses with ALU err flag=1.
  -> o_err_cnt=255; reset -> 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag indices and FSM encoding for the ALU request arbiter
package alu_pkg;

    localparam logic [1:0] OP_SUB  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_ONES = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    localparam int FLAG_ERR = 0;
    localparam int FLAG_NEG = 1;
    localparam int FLAG_POS = 2;
    localparam int FLAG_OVF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant from valids and the previous winner
module rr_arb2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last_grant,
    output logic o_grant0,
    output logic o_grant1
);

    // On contention the requester that did not win last time goes first.
    always_comb begin
        o_grant0 = i_valid0 & (~i_valid1 | i_last_grant);
        o_grant1 = i_valid1 & (~i_valid0 | ~i_last_grant);
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - shares one combinational ALU between two requesters; ALU_ERR_CNT_EN adds o_err_cnt
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OPW   = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
`ifdef ALU_ERR_CNT_EN
    output logic [7:0]       o_err_cnt,
`endif
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [OPW-1:0]   i_req0_oper,
    input  logic [WIDTH-1:0] i_req0_arg0,
    input  logic [WIDTH-1:0] i_req0_arg1,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [OPW-1:0]   i_req1_oper,
    input  logic [WIDTH-1:0] i_req1_arg0,
    input  logic [WIDTH-1:0] i_req1_arg1,
    output logic [WIDTH-1:0] o_alu_arg0,
    output logic [WIDTH-1:0] o_alu_arg1,
    output logic [OPW-1:0]   o_alu_oper,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic [3:0]       i_alu_flag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic [3:0]       o_rsp_flag
);

    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] alu_arg0_q, alu_arg0_d;
    logic [WIDTH-1:0] alu_arg1_q, alu_arg1_d;
    logic [OPW-1:0]   alu_oper_q, alu_oper_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flag_q, rsp_flag_d;
    logic             grant0, grant1;

    rr_arb2 u_rr_arb2 (
        .i_valid0     (i_req0_valid),
        .i_valid1     (i_req1_valid),
        .i_last_grant (last_grant_q),
        .o_grant0     (grant0),
        .o_grant1     (grant1)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        alu_arg0_d   = alu_arg0_q;
        alu_arg1_d   = alu_arg1_q;
        alu_oper_d   = alu_oper_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flag_d   = rsp_flag_q;
        o_req0_ready = (state_q == IDLE) & grant0;
        o_req1_ready = (state_q == IDLE) & grant1;

        case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    alu_arg0_d   = grant1 ? i_req1_arg0 : i_req0_arg0;
                    alu_arg1_d   = grant1 ? i_req1_arg1 : i_req0_arg1;
                    alu_oper_d   = grant1 ? i_req1_oper : i_req0_oper;
                    id_d         = grant1;
                    last_grant_d = grant1;
                    state_d      = EXEC;
                end
            end
            // The ALU has had a full cycle on the registered operands; sample it now.
            EXEC: begin
                rsp_result_d = i_alu_result;
                rsp_flag_d   = i_alu_flag;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            alu_arg0_q   <= '0;
            alu_arg1_q   <= '0;
            alu_oper_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flag_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            alu_arg0_q   <= alu_arg0_d;
            alu_arg1_q   <= alu_arg1_d;
            alu_oper_q   <= alu_oper_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flag_q   <= rsp_flag_d;
        end
    end

`ifdef ALU_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (rsp_valid_q && i_rsp_ready && rsp_flag_q[FLAG_ERR] && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
`endif

    assign o_alu_arg0   = alu_arg0_q;
    assign o_alu_arg1   = alu_arg1_q;
    assign o_alu_oper   = alu_oper_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_result = rsp_result_q;
    assign o_rsp_flag   = rsp_flag_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - scoreboard bench for alu_req_arbiter with a behavioural ALU
module tb_alu_req_arbiter;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       v [0:1];
    logic [1:0] op [0:1];
    logic [3:0] a [0:1];
    logic [3:0] b [0:1];
    logic       r0, r1;
    logic [3:0] alu_a, alu_b, alu_res, alu_flag;
    logic [1:0] alu_op;
    logic       rsp_valid, rsp_ready, rsp_id;
    logic [3:0] rsp_res, rsp_flag;
`ifdef ALU_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_req_arbiter #(.WIDTH(4), .OPW(2)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
`ifdef ALU_ERR_CNT_EN
        .o_err_cnt    (err_cnt),
`endif
        .i_req0_valid (v[0]),
        .o_req0_ready (r0),
        .i_req0_oper  (op[0]),
        .i_req0_arg0  (a[0]),
        .i_req0_arg1  (b[0]),
        .i_req1_valid (v[1]),
        .o_req1_ready (r1),
        .i_req1_oper  (op[1]),
        .i_req1_arg0  (a[1]),
        .i_req1_arg1  (b[1]),
        .o_alu_arg0   (alu_a),
        .o_alu_arg1   (alu_b),
        .o_alu_oper   (alu_op),
        .i_alu_result (alu_res),
        .i_alu_flag   (alu_flag),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_result (rsp_res),
        .o_rsp_flag   (rsp_flag)
    );

    // Behavioural ALU: returns {ovf, pos, neg, err, result}
    function automatic logic [7:0] ref_alu(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
        logic [3:0] res;
        logic ovf, err;
        int n;
        res = 4'd0; ovf = 1'b0; err = 1'b0;
        case (o)
            OP_SUB: begin
                n = (int'(x) - int'(y)) & 15;
                res = 4'(n);
                ovf = (x[3] != y[3]) && (res[3] != x[3]);
            end
            OP_NAND: res = ~(x & y);
            OP_ONES: begin
                n = 0;
                while (n < 4 && x[n]) n++;
                res = 4'(n);
            end
            default: begin
                if ($countones(x) == 1) begin
                    for (int i = 0; i < 4; i++) if (x[i]) res = 4'(i);
                end else err = 1'b1;
            end
        endcase
        return {ovf, (!res[3] && res != 0), res[3], err, res};
    endfunction

    always_comb {alu_flag, alu_res} = ref_alu(alu_op, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the arbitration/transaction rules, evaluated once per cycle.
    logic [8:0] exp_q[$];
    int         grant_log[$];
    bit         m_busy = 0, m_exec = 0, m_resp = 0, m_last = 1;
    logic [8:0] m_cur;
    int         m_err = 0;

    always @(negedge clk) begin
        logic g, e0, e1;
        if (!rstn) begin
            m_busy = 0; m_exec = 0; m_resp = 0; m_last = 1; m_err = 0;
            exp_q.delete();
            grant_log.delete();
        end else begin
            g  = (v[0] && v[1]) ? !m_last : v[1];
            e0 = !m_busy && v[0] && !g;
            e1 = !m_busy && v[1] && g;
            chk("req0_ready", r0, e0);
            chk("req1_ready", r1, e1);
            chk("rsp_valid", rsp_valid, m_resp);
`ifdef ALU_ERR_CNT_EN
            chk("err_cnt", err_cnt, m_err);
`endif
            if (e0 || e1) begin
                m_cur = {g, ref_alu(op[g], a[g], b[g])};
                exp_q.push_back(m_cur);
                grant_log.push_back(int'(g));
                m_busy = 1; m_exec = 1; m_last = g;
            end else if (m_exec) begin
                m_exec = 0; m_resp = 1;
            end else if (m_resp && rsp_ready) begin
                if (m_cur[4] && m_err < 255) m_err++;
                m_resp = 0; m_busy = 0;
            end
        end
    end

    // Monitor: pops the scoreboard when a new response appears, then checks it stays put.
    bit         seen = 0;
    logic [8:0] held;

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rstn) begin
            seen = 0;
        end else if (rsp_valid) begin
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", {rsp_id, rsp_flag, rsp_res}, 9'h1FF ^ {rsp_id, rsp_flag, rsp_res});
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", rsp_id, e[8]);
                    chk("rsp_flag", rsp_flag, e[7:4]);
                    chk("rsp_result", rsp_res, e[3:0]);
                end
                held = {rsp_id, rsp_flag, rsp_res};
                seen = 1;
            end else begin
                chk("rsp_stable", {rsp_id, rsp_flag, rsp_res}, held);
            end
            if (rsp_ready) seen = 0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_acc(input int n);
        bit got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((n == 0) ? r0 : r1) begin got = 1; break; end
        end
        chk("accept_timeout", got, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_alu"}, {alu_a, alu_b, alu_op}, 0);
        chk({name, "_rsp"}, {rsp_valid, rsp_id, rsp_res, rsp_flag}, 0);
    endtask

    task automatic set_req(input int n, input logic vv, input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
        v[n] = vv; op[n] = o; a[n] = x; b[n] = y;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1);
    end

    initial begin
        bit acc0, acc1;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        rsp_ready = 1;
        tick(); tick();
        chk_zero("reset");
        rstn = 1;
        tick();

        // single request: 5 - 3
        set_req(0, 1, OP_SUB, 4'd5, 4'd3);
        wait_acc(0);
        v[0] = 0;
        repeat (4) tick();

        // contention from reset
        rstn = 0;
        set_req(0, 1, OP_NAND, 4'hF, 4'hF);
        set_req(1, 1, OP_SUB, 4'd1, 4'd1);
        tick();
        rstn = 1;
        repeat (13) tick();
        v[0] = 0; v[1] = 0;
        repeat (4) tick();
        chk("grant_count", grant_log.size() >= 4, 1);
        if (grant_log.size() >= 4) begin
            chk("grant_order0", grant_log[0], 0);
            chk("grant_order1", grant_log[1], 1);
            chk("grant_order2", grant_log[2], 0);
            chk("grant_order3", grant_log[3], 1);
        end

        // backpressure with req1 waiting
        rsp_ready = 0;
        set_req(0, 1, OP_ONES, 4'b0111, 4'd0);
        wait_acc(0);
        v[0] = 0;
        set_req(1, 1, OP_DEC, 4'b0100, 4'd9);
        repeat (7) tick();
        rsp_ready = 1;
        wait_acc(1);
        v[1] = 0;
        repeat (4) tick();

        // withdraw during RESP
        rsp_ready = 0;
        set_req(0, 1, OP_SUB, 4'd8, 4'd1);
        wait_acc(0);
        v[0] = 0;
        tick(); tick();
        set_req(1, 1, OP_NAND, 4'h3, 4'h5);
        tick();
        v[1] = 0;
        repeat (3) tick();
        rsp_ready = 1;
        repeat (4) tick();

        // reset during EXEC
        set_req(0, 1, OP_SUB, 4'd5, 4'd3);
        wait_acc(0);
        v[0] = 0;
        rstn = 0;
        tick();
        chk_zero("midreset");
        chk("midreset_ready", {r0, r1}, 0);
        set_req(0, 1, OP_NAND, 4'h6, 4'hA);
        set_req(1, 1, OP_SUB, 4'd2, 4'd7);
        rstn = 1;
        @(negedge clk);
        chk("post_reset_grant0", {r0, r1}, 2'b10);
        tick();
        repeat (8) tick();
        v[0] = 0; v[1] = 0;
        repeat (4) tick();

        // randomized traffic with backpressure and withdrawals
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            acc0 = r0; acc1 = r1;
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) begin
                if (v[n] && ((n == 0) ? acc0 : acc1)) v[n] = ($urandom_range(0, 1) == 1);
                else if (v[n]) begin
                    if ($urandom_range(0, 15) == 0) v[n] = 0;
                end else v[n] = ($urandom_range(0, 2) == 0);
                if (!v[n] || ((n == 0) ? acc0 : acc1)) begin
                    op[n] = 2'($urandom); a[n] = 4'($urandom); b[n] = 4'($urandom);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        v[0] = 0; v[1] = 0; rsp_ready = 1;
        repeat (6) tick();

`ifdef ALU_ERR_CNT_EN
        rstn = 0;
        tick();
        rstn = 1;
        set_req(0, 1, OP_DEC, 4'b0011, 4'd0);
        repeat (960) tick();
        v[0] = 0;
        repeat (5) tick();
        chk("err_cnt_sat", err_cnt, 8'd255);
        rstn = 0;
        tick();
        chk("err_cnt_reset", err_cnt, 8'd0);
        rstn = 1;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
